gemm_insn_dispatch: RTL and testbench



---
 rtl/gemm_insn_dispatch_if.sv | 32 +++
 rtl/gemm_insn_dispatch.sv | 143 ++++++++++++++
 tb/tb_gemm_insn_dispatch.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_insn_dispatch_if.sv
// Bus bundle between instruction fetch / gemm and the compute dispatcher.
// The dispatcher takes the slave side; fetch plus gemm together form the master side.
interface gemm_insn_dispatch_if #(
  parameter int INS_WIDTH  = 128,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [INS_WIDTH-1:0] in_insn;
  logic                 in_valid;
  logic                 in_ready;
  logic                 l2g_tok;
  logic                 s2g_tok;
  logic                 g2l_tok;
  logic                 g2s_tok;
  logic [INS_WIDTH-1:0] insn;
  logic                 insn_start;
  logic                 insn_done;
  logic                 busy;
  logic [CNT_W-1:0]     fifo_count;
  logic                 tok_ovf;

  modport master (
    output in_insn, in_valid, l2g_tok, s2g_tok, insn_done,
    input  in_ready, g2l_tok, g2s_tok, insn, insn_start, busy, fifo_count, tok_ovf
  );

  modport slave (
    input  in_insn, in_valid, l2g_tok, s2g_tok, insn_done,
    output in_ready, g2l_tok, g2s_tok, insn, insn_start, busy, fifo_count, tok_ovf
  );
endinterface

// File: rtl/gemm_insn_dispatch.sv
// Compute-stage dispatcher: queues instructions, waits for load/store dependency
// tokens, starts gemm for GEMM opcodes, and returns tokens after completion.
module gemm_insn_dispatch #(
  parameter int         INS_WIDTH  = 128,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TOK_WIDTH  = 4,
  parameter logic [2:0] GEMM_OP    = 3'h2
) (
  input  logic               clk,
  input  logic               rst,
  gemm_insn_dispatch_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  // Instruction field positions
  localparam int POP_PREV_BIT  = 3;
  localparam int POP_NEXT_BIT  = 4;
  localparam int PUSH_PREV_BIT = 5;
  localparam int PUSH_NEXT_BIT = 6;

  typedef enum logic [1:0] {IDLE, BUSY, PUSH} state_t;

  state_t               state_reg, state_next;
  logic [INS_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [INS_WIDTH-1:0] insn_reg;
  logic                 start_reg;
  logic                 tok_ovf_reg;

  logic [INS_WIDTH-1:0] head;
  logic                 fifo_wr;
  logic                 pop;
  logic                 head_is_gemm;
  logic                 dispatch_ok;
  logic [1:0]           tok_in;
  logic [1:0]           tok_use;
  logic [1:0]           tok_avail;
  logic [1:0]           tok_sat_inc;

  assign head         = fifo_mem[rd_ptr_reg];
  assign head_is_gemm = (head[2:0] == GEMM_OP);
  // Held low during reset so nothing is accepted while the queue is being flushed.
  assign bus.in_ready = rst && (count_reg < CNT_W'(FIFO_DEPTH));
  assign fifo_wr      = bus.in_valid && bus.in_ready;

  // Only registered token counts qualify dispatch; a pulse arriving this cycle waits one edge.
  assign dispatch_ok = (count_reg != '0)
                    && (!head[POP_PREV_BIT] || tok_avail[0])
                    && (!head[POP_NEXT_BIT] || tok_avail[1]);

  // Index 0 is the load->compute counter, index 1 the store->compute counter.
  assign tok_in  = {bus.s2g_tok, bus.l2g_tok};
  assign tok_use = {pop && head[POP_NEXT_BIT], pop && head[POP_PREV_BIT]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tok
      logic [TOK_WIDTH-1:0] cnt_reg;

      // Token counter: arrival and consumption in the same cycle cancel; saturates at all-ones.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (tok_in[gi] && !tok_use[gi]) begin
          if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
        end else if (!tok_in[gi] && tok_use[gi]) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end

      assign tok_avail[gi]   = (cnt_reg != '0);
      assign tok_sat_inc[gi] = tok_in[gi] && !tok_use[gi] && (cnt_reg == '1);
    end
  endgenerate

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst)              tok_ovf_reg <= 1'b0;
    else if (|tok_sat_inc) tok_ovf_reg <= 1'b1;
  end

  // FIFO storage; contents need no reset because the pointers are flushed.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_reg] <= bus.in_insn;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_wr, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // State register plus the latched instruction and its start pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      insn_reg  <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= pop && head_is_gemm;
      if (pop) insn_reg <= head;
    end
  end

  // Next-state and pop decision.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dispatch_ok) begin
          pop        = 1'b1;
          state_next = head_is_gemm ? BUSY : PUSH;
        end
      end
      BUSY:    if (bus.insn_done) state_next = PUSH;
      PUSH:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.insn       = insn_reg;
  assign bus.insn_start = start_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.g2l_tok    = (state_reg == PUSH) && insn_reg[PUSH_PREV_BIT];
  assign bus.g2s_tok    = (state_reg == PUSH) && insn_reg[PUSH_NEXT_BIT];
  assign bus.fifo_count = count_reg;
  assign bus.tok_ovf    = tok_ovf_reg;
endmodule

// File: tb/tb_gemm_insn_dispatch.sv
// Directed bench for gemm_insn_dispatch: each task drives one scenario and checks inline.
module tb_gemm_insn_dispatch;
  localparam int INS_WIDTH  = 128;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   start_seen = 0;
  int   g2l_seen   = 0;
  int   g2s_seen   = 0;

  always #5 clk = ~clk;

  gemm_insn_dispatch_if #(.INS_WIDTH(INS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  gemm_insn_dispatch #(
    .INS_WIDTH(INS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .TOK_WIDTH(4), .GEMM_OP(3'h2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.insn_start) start_seen <= start_seen + 1;
    if (bus.g2l_tok)    g2l_seen   <= g2l_seen + 1;
    if (bus.g2s_tok)    g2s_seen   <= g2s_seen + 1;
  end

  function automatic logic [127:0] mk(input logic [2:0] op, input logic pp, input logic pn,
                                      input logic hp, input logic hn, input logic [15:0] tag);
    return {tag, 105'd0, hn, hp, pn, pp, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_insn = '0; bus.in_valid = 1'b0; bus.l2g_tok = 1'b0;
    bus.s2g_tok = 1'b0; bus.insn_done = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    $display("test_reset: ready=%b count=%0d busy=%b", bus.in_ready, bus.fifo_count, bus.busy);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count got %0d want 0", bus.fifo_count); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.insn !== 128'd0) begin n_fail++; $display("FAIL reset_insn got %h want 0", bus.insn); end
    n_checks++; if ({bus.tok_ovf, bus.insn_start, bus.g2l_tok, bus.g2s_tok} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.tok_ovf, bus.insn_start, bus.g2l_tok, bus.g2s_tok}); end
  endtask

  task automatic test_single_gemm();
    logic [127:0] d;
    int s0, l0, t0;
    do_reset();
    d = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA001);
    s0 = start_seen; l0 = g2l_seen; t0 = g2s_seen;
    bus.in_insn = d; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    $display("test_single_gemm: start=%b insn=%h", bus.insn_start, bus.insn);
    n_checks++; if (bus.insn_start !== 1'b1) begin n_fail++; $display("FAIL single_start got %b want 1", bus.insn_start); end
    n_checks++; if (bus.insn !== d) begin n_fail++; $display("FAIL single_insn got %h want %h", bus.insn, d); end
    n_checks++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count got %0d want 0", bus.fifo_count); end
    tick();
    n_checks++; if (bus.insn_start !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL single_start_pulse got start=%b busy=%b want 0/1", bus.insn_start, bus.busy); end
    repeat (8) tick();
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_push got %b want 1", bus.busy); end
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall got %b want 0", bus.busy); end
    n_checks++; if (start_seen - s0 != 1 || g2l_seen != l0 || g2s_seen != t0) begin
      n_fail++; $display("FAIL single_pulses got start=%0d g2l=%0d g2s=%0d want 1/0/0", start_seen - s0, g2l_seen - l0, g2s_seen - t0); end
  endtask

  task automatic test_dep_stall();
    logic [127:0] d;
    int s0, l0, t0;
    do_reset();
    d = mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'hB002);
    s0 = start_seen; l0 = g2l_seen; t0 = g2s_seen;
    bus.in_insn = d; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (20) tick();
    $display("test_dep_stall: stalled count=%0d busy=%b", bus.fifo_count, bus.busy);
    n_checks++; if (start_seen != s0 || bus.busy !== 1'b0 || bus.fifo_count !== 3'd1) begin
      n_fail++; $display("FAIL dep_stall got starts=%0d busy=%b count=%0d want 0/0/1", start_seen - s0, bus.busy, bus.fifo_count); end
    bus.l2g_tok = 1'b1;
    tick();
    bus.l2g_tok = 1'b0;
    n_checks++; if (bus.insn_start !== 1'b0 || dut.g_tok[0].cnt_reg !== 4'd1) begin
      n_fail++; $display("FAIL dep_tok_arrive got start=%b cnt=%0d want 0/1", bus.insn_start, dut.g_tok[0].cnt_reg); end
    tick();
    n_checks++; if (bus.insn_start !== 1'b1 || dut.g_tok[0].cnt_reg !== 4'd0) begin
      n_fail++; $display("FAIL dep_start got start=%b cnt=%0d want 1/0", bus.insn_start, dut.g_tok[0].cnt_reg); end
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    n_checks++; if (bus.g2s_tok !== 1'b1 || bus.g2l_tok !== 1'b0) begin
      n_fail++; $display("FAIL dep_push got g2s=%b g2l=%b want 1/0", bus.g2s_tok, bus.g2l_tok); end
    tick();
    n_checks++; if (g2s_seen - t0 != 1 || g2l_seen != l0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL dep_pulses got g2s=%0d g2l=%0d busy=%b want 1/0/0", g2s_seen - t0, g2l_seen - l0, bus.busy); end
  endtask

  task automatic test_fifo_full();
    logic [127:0] b;
    do_reset();
    bus.in_insn = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC000); bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    b = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC001);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_insn = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC001 + 16'(i));
      tick();
    end
    $display("test_fifo_full: count=%0d ready=%b", bus.fifo_count, bus.in_ready);
    n_checks++; if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_state got count=%0d ready=%b want 4/0", bus.fifo_count, bus.in_ready); end
    bus.in_insn = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC0FF);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_fifth got count=%0d want 4", bus.fifo_count); end
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    tick();
    n_checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL full_idle got ready=%b busy=%b want 0/0", bus.in_ready, bus.busy); end
    tick();
    n_checks++; if (bus.fifo_count !== 3'd3 || bus.in_ready !== 1'b1 || bus.insn !== b || bus.insn_start !== 1'b1) begin
      n_fail++; $display("FAIL full_pop got count=%0d ready=%b start=%b insn=%h want 3/1/1 %h",
                         bus.fifo_count, bus.in_ready, bus.insn_start, bus.insn, b); end
  endtask

  task automatic test_non_gemm();
    logic [127:0] d;
    int s0, l0;
    do_reset();
    d = mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'hD003);
    s0 = start_seen; l0 = g2l_seen;
    bus.in_insn = d; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    $display("test_non_gemm: g2l=%b start=%b insn=%h", bus.g2l_tok, bus.insn_start, bus.insn);
    n_checks++; if (bus.g2l_tok !== 1'b1 || bus.insn_start !== 1'b0 || bus.insn !== d) begin
      n_fail++; $display("FAIL nongemm_push got g2l=%b start=%b insn=%h want 1/0 %h", bus.g2l_tok, bus.insn_start, bus.insn, d); end
    tick();
    n_checks++; if (bus.g2l_tok !== 1'b0 || bus.busy !== 1'b0 || start_seen != s0 || g2l_seen - l0 != 1) begin
      n_fail++; $display("FAIL nongemm_done got g2l=%b busy=%b starts=%0d g2l_n=%0d want 0/0/0/1",
                         bus.g2l_tok, bus.busy, start_seen - s0, g2l_seen - l0); end
  endtask

  task automatic test_tokens();
    do_reset();
    bus.l2g_tok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) begin
        n_checks++; if (dut.g_tok[0].cnt_reg !== 4'd15 || bus.tok_ovf !== 1'b0) begin
          n_fail++; $display("FAIL tok_fifteen got cnt=%0d ovf=%b want 15/0", dut.g_tok[0].cnt_reg, bus.tok_ovf); end
      end
    end
    bus.l2g_tok = 1'b0;
    $display("test_tokens: l2g_cnt=%0d ovf=%b", dut.g_tok[0].cnt_reg, bus.tok_ovf);
    n_checks++; if (dut.g_tok[0].cnt_reg !== 4'd15 || bus.tok_ovf !== 1'b1) begin
      n_fail++; $display("FAIL tok_sat got cnt=%0d ovf=%b want 15/1", dut.g_tok[0].cnt_reg, bus.tok_ovf); end
    bus.s2g_tok = 1'b1;
    tick();
    bus.s2g_tok = 1'b0;
    n_checks++; if (dut.g_tok[1].cnt_reg !== 4'd1) begin n_fail++; $display("FAIL tok_s2g got %0d want 1", dut.g_tok[1].cnt_reg); end
    bus.in_insn = mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'hE001); bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.l2g_tok = 1'b1;
    tick();
    bus.l2g_tok = 1'b0;
    n_checks++; if (dut.g_tok[0].cnt_reg !== 4'd15 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL tok_simul got cnt=%0d busy=%b want 15/1", dut.g_tok[0].cnt_reg, bus.busy); end
    tick();
    bus.in_insn = mk(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'hE002); bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (dut.g_tok[0].cnt_reg !== 4'd14 || dut.g_tok[1].cnt_reg !== 4'd0 || bus.tok_ovf !== 1'b1) begin
      n_fail++; $display("FAIL tok_consume got l2g=%0d s2g=%0d ovf=%b want 14/0/1",
                         dut.g_tok[0].cnt_reg, dut.g_tok[1].cnt_reg, bus.tok_ovf); end
    tick();
  endtask

  // Runs straight after test_tokens so tok_ovf is set going in and must be cleared.
  task automatic test_reset_mid_busy();
    int s0, l0, t0;
    bus.in_insn = mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF000); bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_insn = mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF001);
    tick();
    bus.in_insn = mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF002);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.fifo_count !== 3'd2) begin
      n_fail++; $display("FAIL rstmid_pre got busy=%b count=%0d want 1/2", bus.busy, bus.fifo_count); end
    rst = 1'b0;
    tick();
    $display("test_reset_mid_busy: busy=%b count=%0d insn=%h", bus.busy, bus.fifo_count, bus.insn);
    n_checks++; if (bus.busy !== 1'b0 || bus.fifo_count !== 3'd0 || bus.insn !== 128'd0) begin
      n_fail++; $display("FAIL rstmid_state got busy=%b count=%0d insn=%h want 0/0/0", bus.busy, bus.fifo_count, bus.insn); end
    n_checks++; if ({bus.tok_ovf, bus.insn_start, bus.g2l_tok, bus.g2s_tok} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_flags got %b want 0000", {bus.tok_ovf, bus.insn_start, bus.g2l_tok, bus.g2s_tok}); end
    rst = 1'b1;
    s0 = start_seen; l0 = g2l_seen; t0 = g2s_seen;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", bus.in_ready); end
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    repeat (3) tick();
    n_checks++; if (start_seen != s0 || g2l_seen != l0 || g2s_seen != t0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_done_ignored got starts=%0d g2l=%0d g2s=%0d busy=%b want 0/0/0/0",
                         start_seen - s0, g2l_seen - l0, g2s_seen - t0, bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single_gemm();
    test_dep_stall();
    test_fifo_full();
    test_non_gemm();
    test_tokens();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
